pc_unit: RTL and testbench

- Program-counter register and next-PC selection for the IF stage of the 5-stage MIPS pipeline.
- Holds the current PC and drives the instruction memory address.
- Drives the pc_adder input and its enable; the pc_adder's +4 result comes back as the sequential next PC.
- Applies stall from the hazard unit, branch/jump redirects from ID, HALT, and the debug unit's continuous or single-step run modes.

---
 rtl/pc_unit_pkg.sv | 22 ++
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_next_mux.sv | 30 +++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared encodings for the IF-stage program counter: FSM states, next-PC sources, alignment mask.
// Imported by pc_unit, pc_next_mux and the pc_unit_if interface users.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    // Clears the two byte-offset bits; sliced down to the PC width at the point of use.
    localparam logic [63:0] ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/pc_unit_if.sv
// Debug/hazard/ID-side control and PC outputs of the IF-stage program counter.
// slave = pc_unit, master = whoever drives the controls (pipeline glue or a bench).
interface pc_unit_if #(
    parameter int PC_SZ = 32
);
    logic             i_enable;
    logic             i_run_mode;
    logic             i_step;
    logic             i_stall;
    logic             i_halt;
    logic [1:0]       i_pc_src;
    logic [PC_SZ-1:0] i_pc_seq;
    logic [PC_SZ-1:0] i_branch_addr;
    logic [PC_SZ-1:0] i_jump_addr;
    logic [PC_SZ-1:0] i_jr_addr;

    logic [PC_SZ-1:0] o_pc;
    logic             o_pc_en;
    logic             o_halted;
    logic [1:0]       o_state;
    logic             o_fault;

    modport master (
        output i_enable, i_run_mode, i_step, i_stall, i_halt, i_pc_src,
               i_pc_seq, i_branch_addr, i_jump_addr, i_jr_addr,
        input  o_pc, o_pc_en, o_halted, o_state, o_fault
    );

    modport slave (
        input  i_enable, i_run_mode, i_step, i_stall, i_halt, i_pc_src,
               i_pc_seq, i_branch_addr, i_jump_addr, i_jr_addr,
        output o_pc, o_pc_en, o_halted, o_state, o_fault
    );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC target select (sequential / branch / jump / jump-register) with forced word alignment.
module pc_next_mux
    import pc_unit_pkg::*;
#(
    parameter int PC_SZ = 32
) (
    input  pc_src_e          pc_src,
    input  logic [PC_SZ-1:0] seq,
    input  logic [PC_SZ-1:0] branch,
    input  logic [PC_SZ-1:0] jump,
    input  logic [PC_SZ-1:0] jr,
    output logic [PC_SZ-1:0] target
);

    logic [PC_SZ-1:0] raw;

    always_comb begin
        raw = seq;
        case (pc_src)
            PC_SRC_SEQ:    raw = seq;
            PC_SRC_BRANCH: raw = branch;
            PC_SRC_JUMP:   raw = jump;
            PC_SRC_JR:     raw = jr;
            default:       raw = seq;
        endcase
    end

    assign target = raw & ALIGN_MASK[PC_SZ-1:0];

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: run/step/halt FSM, step edge detect and PC register.
// Optional macro PC_BOUNDS_CHECK_EN: targets at or beyond IMEM_DEPTH*4 halt the core with a sticky fault.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               PC_SZ      = 32,
    parameter logic [PC_SZ-1:0] RESET_PC   = '0,
    parameter int               IMEM_DEPTH = 256
) (
    input  logic      i_clk,
    input  logic      i_reset,
    pc_unit_if.slave  bus
);

    state_e           state;
    logic [PC_SZ-1:0] pc_q;
    logic [PC_SZ-1:0] target;
    logic             step_q;
    logic             halted_q;
    logic             fault_q;
    logic             step_edge;
    logic             go;
    logic             out_of_range;
    logic             halt_now;
    logic             fault_now;
    logic             update;

    pc_next_mux #(.PC_SZ(PC_SZ)) u_next_mux (
        .pc_src (pc_src_e'(bus.i_pc_src)),
        .seq    (bus.i_pc_seq),
        .branch (bus.i_branch_addr),
        .jump   (bus.i_jump_addr),
        .jr     (bus.i_jr_addr),
        .target (target)
    );

`ifdef PC_BOUNDS_CHECK_EN
    localparam logic [PC_SZ:0] PC_LIMIT = (PC_SZ+1)'(IMEM_DEPTH) << 2;
    assign out_of_range = ({1'b0, target} >= PC_LIMIT);
`else
    assign out_of_range = 1'b0;
`endif

    assign step_edge = bus.i_step & ~step_q;

    // "go" marks a cycle that wants to advance: every RUN cycle, or a fresh step edge in STEP.
    always_comb begin
        go = 1'b0;
        case (state)
            ST_RUN:  go = 1'b1;
            ST_STEP: go = step_edge;
            default: go = 1'b0;
        endcase
    end

    assign halt_now  = go & bus.i_halt;
    assign fault_now = go & ~bus.i_halt & ~bus.i_stall & out_of_range;
    assign update    = go & ~bus.i_halt & ~bus.i_stall & ~out_of_range;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            pc_q     <= RESET_PC;
            step_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            step_q <= bus.i_step;
            case (state)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        state <= bus.i_run_mode ? ST_RUN : ST_STEP;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (halt_now) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (fault_now) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                        fault_q  <= 1'b1;
                    end else if (update) begin
                        pc_q <= target;
                    end
                end
                default: begin
                    state <= ST_HALTED;
                end
            endcase
        end
    end

    // pc_en is combinational so the pc_adder passes the PC through unchanged whenever we hold.
    assign bus.o_pc     = pc_q;
    assign bus.o_pc_en  = update;
    assign bus.o_halted = halted_q;
    assign bus.o_state  = state;
    assign bus.o_fault  = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_pc_unit;

    localparam int          PC_SZ      = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 256;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;
`ifdef PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_state;
    logic [31:0] m_pc;
    logic        m_step_prev;
    logic        m_fault;
    logic        exp_pc_en;
    logic        seen_pc_en;

    pc_unit_if #(.PC_SZ(PC_SZ)) pif ();

    pc_unit #(.PC_SZ(PC_SZ), .RESET_PC(RESET_PC), .IMEM_DEPTH(IMEM_DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (pif.slave)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state     = M_IDLE;
        m_pc        = RESET_PC;
        m_step_prev = 1'b0;
        m_fault     = 1'b0;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] src, input logic [31:0] sq,
                                         input logic [31:0] br, input logic [31:0] jp, input logic [31:0] jr);
        logic [31:0] t;
        case (src)
            2'd0:    t = sq;
            2'd1:    t = br;
            2'd2:    t = jp;
            default: t = jr;
        endcase
        return t - (t % 32'd4);
    endfunction

    // Drives one cycle from posedge+1, captures pc_en at the negedge, and advances the model.
    task automatic apply_stimulus(input logic en, input logic rm, input logic st, input logic sl,
                                  input logic hl, input logic [1:0] src, input logic [31:0] br,
                                  input logic [31:0] jp, input logic [31:0] jr);
        bit go, oob;
        logic [31:0] tgt;
        pif.i_enable = en; pif.i_run_mode = rm; pif.i_step = st; pif.i_stall = sl; pif.i_halt = hl;
        pif.i_pc_src = src; pif.i_pc_seq = m_pc + 32'd4;
        pif.i_branch_addr = br; pif.i_jump_addr = jp; pif.i_jr_addr = jr;
        go  = (m_state == M_RUN) || (m_state == M_STEP && st && !m_step_prev);
        tgt = pick(src, m_pc + 32'd4, br, jp, jr);
        oob = BOUNDS && (longint'(tgt) >= longint'(IMEM_DEPTH) * 4);
        exp_pc_en = go && !hl && !sl && !oob;
        @(negedge clk);
        seen_pc_en = pif.o_pc_en;
        @(posedge clk);
        #1;
        if (m_state == M_IDLE) begin
            if (en) m_state = rm ? M_RUN : M_STEP;
        end else if (go && hl) begin
            m_state = M_HALTED;
        end else if (go && !sl && oob) begin
            m_state = M_HALTED;
            m_fault = 1'b1;
        end else if (exp_pc_en) begin
            m_pc = tgt;
        end
        m_step_prev = st;
    endtask

    task automatic seq_cycle(input logic st, input logic sl);
        apply_stimulus(1'b0, 1'b0, st, sl, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pif.i_enable = 0; pif.i_run_mode = 0; pif.i_step = 0; pif.i_stall = 0; pif.i_halt = 0;
        pif.i_pc_src = 0; pif.i_pc_seq = 0; pif.i_branch_addr = 0; pif.i_jump_addr = 0; pif.i_jr_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        pif.i_enable = 1'b1; pif.i_run_mode = 1'b1;
        @(negedge clk);
        n_checks++; if (pif.o_pc !== RESET_PC) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pif.o_pc, RESET_PC); end
        n_checks++; if (pif.o_state !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_state: got %b expected 00", pif.o_state); end
        n_checks++; if (pif.o_halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b expected 0", pif.o_halted); end
        n_checks++; if (pif.o_fault !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fault: got %b expected 0", pif.o_fault); end
        n_checks++; if (pif.o_pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pc_en: got %b expected 0", pif.o_pc_en); end
        do_reset();
        n_checks++; if (pif.o_state !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_hold_state: got %b expected 00", pif.o_state); end
    endtask

    task automatic test_run_sequence();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        n_checks++; if (pif.o_state !== 2'b01) begin n_fail++; $display("[TB] FAIL run_enter_state: got %b expected 01", pif.o_state); end
        n_checks++; if (seen_pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_pc_en: got %b expected 0", seen_pc_en); end
        n_checks++; if (pif.o_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL run_pc0: got %h expected 0", pif.o_pc); end
        for (int i = 1; i <= 3; i++) begin
            seq_cycle(1'b0, 1'b0);
            n_checks++; if (pif.o_pc !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL run_pc_seq: got %h expected %h", pif.o_pc, 32'(4 * i)); end
            n_checks++; if (seen_pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL run_pc_en: got %b expected 1", seen_pc_en); end
        end
    endtask

    task automatic test_stall_branch();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        seq_cycle(1'b0, 1'b0);
        seq_cycle(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h40, 32'h0, 32'h0);
            n_checks++; if (pif.o_pc !== 32'h8) begin n_fail++; $display("[TB] FAIL stall_hold_pc: got %h expected 8", pif.o_pc); end
            n_checks++; if (seen_pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_pc_en: got %b expected 0", seen_pc_en); end
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h40, 32'h0, 32'h0);
        n_checks++; if (pif.o_pc !== 32'h40) begin n_fail++; $display("[TB] FAIL branch_pc: got %h expected 40", pif.o_pc); end
        n_checks++; if (seen_pc_en !== 1'b1) begin n_fail++; $display("[TB] FAIL branch_pc_en: got %b expected 1", seen_pc_en); end
    endtask

    task automatic test_halt();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h80, 32'h0);
        n_checks++; if (pif.o_pc !== 32'h40) begin n_fail++; $display("[TB] FAIL halt_pc: got %h expected 40", pif.o_pc); end
        n_checks++; if (pif.o_state !== 2'b11) begin n_fail++; $display("[TB] FAIL halt_state: got %b expected 11", pif.o_state); end
        n_checks++; if (pif.o_halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_flag: got %b expected 1", pif.o_halted); end
        n_checks++; if (seen_pc_en !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_pc_en: got %b expected 0", seen_pc_en); end
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 2'($urandom), $urandom, $urandom, $urandom);
            n_checks++; if (pif.o_pc !== 32'h40 || pif.o_state !== 2'b11) begin
                n_fail++; $display("[TB] FAIL halt_frozen: got pc %h state %b expected pc 40 state 11", pif.o_pc, pif.o_state); end
        end
    endtask

    task automatic test_single_step();
        int en_count;
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        n_checks++; if (pif.o_state !== 2'b10) begin n_fail++; $display("[TB] FAIL step_state: got %b expected 10", pif.o_state); end
        en_count = 0;
        for (int i = 0; i < 5; i++) begin
            seq_cycle(1'b1, 1'b0);
            en_count += int'(seen_pc_en);
        end
        n_checks++; if (pif.o_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL step_long_pulse_pc: got %h expected 4", pif.o_pc); end
        n_checks++; if (en_count !== 1) begin n_fail++; $display("[TB] FAIL step_pc_en_count: got %0d expected 1", en_count); end
        seq_cycle(1'b0, 1'b0);
        seq_cycle(1'b1, 1'b0);
        n_checks++; if (pif.o_pc !== 32'h8) begin n_fail++; $display("[TB] FAIL step_second_pc: got %h expected 8", pif.o_pc); end
        seq_cycle(1'b0, 1'b0);
        seq_cycle(1'b1, 1'b1);
        seq_cycle(1'b1, 1'b0);
        n_checks++; if (pif.o_pc !== 32'h8) begin n_fail++; $display("[TB] FAIL step_stall_consumed_pc: got %h expected 8", pif.o_pc); end
        seq_cycle(1'b0, 1'b0);
        seq_cycle(1'b1, 1'b0);
        n_checks++; if (pif.o_pc !== 32'hC) begin n_fail++; $display("[TB] FAIL step_third_pc: got %h expected c", pif.o_pc); end
    endtask

    task automatic test_alignment_jr();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0000_0047);
        n_checks++; if (pif.o_pc !== 32'h0000_0044) begin n_fail++; $display("[TB] FAIL jr_align_pc: got %h expected 44", pif.o_pc); end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h0000_0013, 32'h0, 32'h0);
        n_checks++; if (pif.o_pc !== 32'h0000_0010) begin n_fail++; $display("[TB] FAIL branch_align_pc: got %h expected 10", pif.o_pc); end
        if (!BOUNDS) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'hFFFF_FFFE, 32'h0);
            n_checks++; if (pif.o_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL top_pc: got %h expected fffffffc", pif.o_pc); end
            seq_cycle(1'b0, 1'b0);
            n_checks++; if (pif.o_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 0", pif.o_pc); end
        end
    endtask

    task automatic test_bounds();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h3FC, 32'h0, 32'h0);
        n_checks++; if (pif.o_pc !== 32'h3FC) begin n_fail++; $display("[TB] FAIL bound_last_pc: got %h expected 3fc", pif.o_pc); end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h400, 32'h0);
        if (BOUNDS) begin
            n_checks++; if (pif.o_pc !== 32'h3FC) begin n_fail++; $display("[TB] FAIL bound_hold_pc: got %h expected 3fc", pif.o_pc); end
            n_checks++; if (pif.o_fault !== 1'b1 || pif.o_halted !== 1'b1) begin
                n_fail++; $display("[TB] FAIL bound_fault: got fault %b halted %b expected 1 1", pif.o_fault, pif.o_halted); end
        end else begin
            n_checks++; if (pif.o_pc !== 32'h400) begin n_fail++; $display("[TB] FAIL nobound_pc: got %h expected 400", pif.o_pc); end
            n_checks++; if (pif.o_fault !== 1'b0 || pif.o_halted !== 1'b0) begin
                n_fail++; $display("[TB] FAIL nobound_fault: got fault %b halted %b expected 0 0", pif.o_fault, pif.o_halted); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) seq_cycle(1'b0, 1'b0);
        n_checks++; if (pif.o_pc !== 32'hC) begin n_fail++; $display("[TB] FAIL pre_reset_pc: got %h expected c", pif.o_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pif.o_pc !== RESET_PC) begin n_fail++; $display("[TB] FAIL async_reset_pc: got %h expected %h", pif.o_pc, RESET_PC); end
        n_checks++; if (pif.o_state !== 2'b00) begin n_fail++; $display("[TB] FAIL async_reset_state: got %b expected 00", pif.o_state); end
        do_reset();
    endtask

    task automatic test_random();
        logic [31:0] br, jp, jr;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_state == M_HALTED && $urandom_range(0, 3) == 0) do_reset();
            br = BOUNDS ? 32'($urandom_range(0, 1100)) : $urandom;
            jp = BOUNDS ? 32'($urandom_range(0, 1100)) : $urandom;
            jr = BOUNDS ? 32'($urandom_range(0, 1100)) : $urandom;
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                           $urandom_range(0, 19) == 0, 2'($urandom), br, jp, jr);
            n_checks++; if (pif.o_pc !== m_pc) begin n_fail++; $display("[TB] FAIL rand_pc: got %h expected %h", pif.o_pc, m_pc); end
            n_checks++; if (pif.o_state !== 2'(m_state)) begin n_fail++; $display("[TB] FAIL rand_state: got %b expected %b", pif.o_state, 2'(m_state)); end
            n_checks++; if (pif.o_halted !== (m_state == M_HALTED)) begin n_fail++; $display("[TB] FAIL rand_halted: got %b expected %b", pif.o_halted, m_state == M_HALTED); end
            n_checks++; if (pif.o_fault !== m_fault) begin n_fail++; $display("[TB] FAIL rand_fault: got %b expected %b", pif.o_fault, m_fault); end
            n_checks++; if (seen_pc_en !== exp_pc_en) begin n_fail++; $display("[TB] FAIL rand_pc_en: got %b expected %b", seen_pc_en, exp_pc_en); end
        end
    endtask

    initial begin
        test_reset();
        test_run_sequence();
        test_stall_branch();
        test_halt();
        test_single_step();
        test_alignment_jr();
        test_bounds();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
